s3g_rx_buf: RTL and testbench
=============================

// Module: s3g_rx_buf
// PURPOSE
//  Parametrised S3G packet receiver with on-chip payload buffer. Consumes UART bytes (rx_data/rx_done),
//  frames 0xD5 | len | payload | CRC8, validates CRC and length, holds a good packet until acknowledged.
//  Sits between the UART RX and the command decoder; decoder reads payload by address.
// PARAMETERS
//  MAX_PAYLOAD     32     max accepted payload bytes (1..255); also buffer depth
//  ADDR_W          5      buffer address width, 2**ADDR_W >= MAX_PAYLOAD
//  TIMEOUT_CYCLES  50000  inter-byte timeout in clk cycles (used only with S3G_RX_TIMEOUT_EN)
//  TO_W            16     timeout counter width, 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active high
//  rx_data       in   8       received byte, valid when rx_done=1
//  rx_done       in   1       one-cycle byte strobe
//  packet_ready  out  1       good packet held in buffer
//  payload_len   out  8       length of held packet, valid while packet_ready
//  rd_addr       in   ADDR_W  payload read address
//  rd_data       out  8       buf[rd_addr], registered, 1-cycle latency
//  packet_ack    in   1       decoder done; releases buffer
//  busy          out  1       1 in any state except IDLE
//  crc_err       out  1       one-cycle pulse: CRC mismatch
//  len_err       out  1       one-cycle pulse: len==0 or len>MAX_PAYLOAD
//  overrun_err   out  1       one-cycle pulse: byte received while holding packet
//  timeout_err   out  1       one-cycle pulse: inter-byte timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; crc, index, len, counter cleared. Buffer RAM not cleared.
//  - Reset mid-packet: partial packet discarded, no error pulse; held packet dropped.
//  - States: IDLE, LEN, PAYLOAD, CRC, HOLD. All transitions only on rx_done unless noted.
//  - IDLE: byte==0xD5 -> LEN (crc<=0, idx<=0); any other byte silently discarded.
//  - LEN: byte in 1..MAX_PAYLOAD -> latch len, PAYLOAD; else len_err pulse, IDLE.
//  - PAYLOAD: buf[idx]<=byte, crc<=crc8(crc,byte), idx++; byte with idx==len-1 -> CRC.
//  - CRC: byte==crc -> packet_ready<=1 next cycle, payload_len<=len, HOLD; else crc_err, IDLE.
//  - HOLD: rx_done -> byte dropped, overrun_err pulse, stay HOLD. packet_ack -> packet_ready<=0, IDLE.
//    packet_ack and rx_done same cycle in HOLD: byte dropped, overrun_err pulses, state -> IDLE.
//  - packet_ack outside HOLD ignored.
//  - CRC8: Dallas/Maxim, reflected poly 0x8C, init 0x00, over payload bytes only (not 0xD5, not len).
//    Bitwise per byte in one cycle: 8x {c^=d_lsb; c=(c>>1)^(lsb?0x8C:0)}.
//  - rd_data registered every cycle from buf[rd_addr]; valid content only while packet_ready.
//    rd_addr >= MAX_PAYLOAD returns undefined data; no error.
//  - Buffer is written only in PAYLOAD; held packet never overwritten in HOLD.
//  - Error pulses are exactly one cycle, the cycle after the offending rx_done; mutually exclusive.
// CONFIGURATION
//  S3G_RX_TIMEOUT_EN defined: counter cleared on every rx_done and on entry to LEN; increments each
//   cycle in LEN/PAYLOAD/CRC; reaching TIMEOUT_CYCLES -> timeout_err pulse, IDLE, partial packet lost.
//   Counter idle (0) in IDLE and HOLD. rx_done on the terminal cycle wins: byte processed, no timeout.
//  S3G_RX_TIMEOUT_EN undefined: no counter logic; timeout_err tied 0; receiver waits forever.
// TESTING
//  1. D5 03 01 02 03 D8 -> packet_ready=1, payload_len=3, rd_data at addr 0/1/2 = 01/02/03.
//  2. D5 03 01 02 03 CC -> crc_err one pulse, packet_ready stays 0, busy=0 after.
//  3. D5 00 and D5 (MAX_PAYLOAD+1) -> len_err pulse each, back to IDLE; then test 1 passes.
//  4. Test 1, then 0D before ack -> overrun_err pulse, rd_data still 01/02/03; packet_ack -> ready=0.
//  5. Junk 0D 13 then test 1; rst asserted after D5 03 01 -> busy=0, no pulses, next packet accepted.
//  6. (S3G_RX_TIMEOUT_EN, TIMEOUT_CYCLES=20) D5 03 01, then 20 idle cycles -> timeout_err pulse, IDLE.

Source files
------------

// File: rtl/s3g_rx_buf.sv
// S3G packet receiver: frames 0xD5 | len | payload | CRC8 from UART bytes and holds a good payload until acked.
// Optional inter-byte timeout is compiled in with `define S3G_RX_TIMEOUT_EN.
module s3g_rx_buf #(
  parameter int MAX_PAYLOAD    = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              packet_ready,
  output logic [7:0]        payload_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              packet_ack,
  output logic              busy,
  output logic              crc_err,
  output logic              len_err,
  output logic              overrun_err,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CRC, HOLD} state_t;

  localparam logic [7:0] SOF  = 8'hD5;
  localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);

  state_t      state, nxt;
  logic [7:0]  crc, idx, len;
  logic [7:0]  mem [2**ADDR_W];
  logic        len_ok, crc_ok, last, to_hit;
  logic        crc_err_d, len_err_d, overrun_err_d, timeout_err_d;

  function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign len_ok = (rx_data != 8'd0) && (rx_data <= MAXP);
  assign crc_ok = (rx_data == crc);
  assign last   = (idx == len - 8'd1);

`ifdef S3G_RX_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_run;

  assign to_run = (state == LEN) || (state == PAYLOAD) || (state == CRC);
  // A byte arriving on the terminal cycle takes precedence over the timeout.
  assign to_hit = to_run && !rx_done && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_done || !to_run || to_hit) to_cnt <= '0;
    else                                     to_cnt <= to_cnt + 1'b1;
  end
`else
  // Timeout parameters stay in the interface; this evaluates to constant 0.
  assign to_hit = (TIMEOUT_CYCLES < 0) || (TO_W < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (to_hit) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (rx_done && rx_data == SOF) nxt = LEN;
        LEN:     if (rx_done) nxt = len_ok ? PAYLOAD : IDLE;
        PAYLOAD: if (rx_done && last) nxt = CRC;
        CRC:     if (rx_done) nxt = crc_ok ? HOLD : IDLE;
        HOLD:    if (packet_ack) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    crc_err_d     = (state == CRC) && rx_done && !crc_ok;
    len_err_d     = (state == LEN) && rx_done && !len_ok;
    overrun_err_d = (state == HOLD) && rx_done;
    timeout_err_d = to_hit;
  end

  assign busy         = (state != IDLE);
  assign packet_ready = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc         <= '0;
      idx         <= '0;
      len         <= '0;
      payload_len <= '0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      crc_err     <= crc_err_d;
      len_err     <= len_err_d;
      overrun_err <= overrun_err_d;
      timeout_err <= timeout_err_d;
      if (rx_done) begin
        case (state)
          IDLE:    if (rx_data == SOF) begin
                     crc <= '0;
                     idx <= '0;
                   end
          LEN:     if (len_ok) len <= rx_data;
          PAYLOAD: begin
                     crc <= crc8(crc, rx_data);
                     idx <= idx + 8'd1;
                   end
          CRC:     if (crc_ok) payload_len <= len;
          default: ;
        endcase
      end
    end
  end

  // Payload RAM is never reset and only written while receiving payload.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_done) mem[idx[ADDR_W-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_s3g_rx_buf.sv
// Scoreboard bench for s3g_rx_buf: expected events are queued as bytes are driven, popped by a monitor.
module tb_s3g_rx_buf;
  localparam int MAXP = 32;
  localparam int AW   = 5;
`ifdef S3G_RX_TIMEOUT_EN
  localparam int TOC  = 20;
`else
  localparam int TOC  = 50000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic          packet_ready;
  logic [7:0]    payload_len;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          packet_ack = 1'b0;
  logic          busy, crc_err, len_err, overrun_err, timeout_err;

  s3g_rx_buf #(.MAX_PAYLOAD(MAXP), .ADDR_W(AW), .TIMEOUT_CYCLES(TOC), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .packet_ready(packet_ready), .payload_len(payload_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .packet_ack(packet_ack), .busy(busy), .crc_err(crc_err),
    .len_err(len_err), .overrun_err(overrun_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ev bits: {timeout, overrun, len, crc}; len != 0 marks a packet_ready rise.
  typedef struct {
    string      tag;
    logic [3:0] ev;
    logic [7:0] len;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pl [256];
  logic       prev_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ev;
    logic       rise;
    exp_t       e;
    ev       = {timeout_err, overrun_err, len_err, crc_err};
    rise     = packet_ready && !prev_rdy;
    prev_rdy = packet_ready;
    if (ev != 4'd0 || rise) begin
      if (sb.size() == 0) chk("unexpected_event", {27'd0, rise, ev}, 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_ev"}, {27'd0, rise, ev}, {27'd0, (e.len != 8'd0), e.ev});
        if (rise) chk({e.tag, "_len"}, 32'(payload_len), 32'(e.len));
      end
    end
  end

  function automatic logic [7:0] crc_model(input int n);
    logic [7:0] c;
    logic       mix;
    c = 8'h00;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        mix = c[0] ^ pl[i][b];
        c   = {1'b0, c[7:1]};
        if (mix) c = c ^ 8'h8C;
      end
    return c;
  endfunction

  function automatic void push(input string tag, input logic [3:0] ev, input logic [7:0] len);
    exp_t e;
    e.tag = tag; e.ev = ev; e.len = len;
    sb.push_back(e);
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit good);
    logic [7:0] c;
    send(8'hD5);
    send(8'(n));
    for (int i = 0; i < n; i++) send(pl[i]);
    c = crc_model(n);
    if (good) begin
      push("pkt", 4'b0000, 8'(n));
      send(c);
    end else begin
      push("crc", 4'b0001, 8'd0);
      send(c ^ 8'h14);
    end
  endtask

  task automatic load123();
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
  endtask

  task automatic rd_chk(input int a, input logic [7:0] exp);
    @(posedge clk); #1;
    rd_addr = AW'(a);
    @(posedge clk);
    @(negedge clk);
    chk("rd_data", 32'(rd_data), 32'(exp));
  endtask

  task automatic readback(input int n);
    for (int i = 0; i < n; i++) rd_chk(i, pl[i]);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic ack();
    @(posedge clk); #1 packet_ack = 1'b1;
    @(posedge clk); #1 packet_ack = 1'b0;
    @(negedge clk);
    chk("ack_ready", 32'(packet_ready), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {20'd0, packet_ready, busy, crc_err, len_err, overrun_err, timeout_err, 6'd0},
        32'd0);
    chk("rst_len", 32'(payload_len), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // basic good packet, CRC of 01 02 03 is D8
    load123();
    chk("crc_model_ref", 32'(crc_model(3)), 32'h0000_00D8);
    send_pkt(3, 1'b1);
    drain();
    chk("t1_ready", 32'(packet_ready), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    readback(3);
    ack();

    // bad CRC (CC)
    send_pkt(3, 1'b0);
    drain();
    chk("t2_ready", 32'(packet_ready), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // length boundaries
    push("len0", 4'b0010, 8'd0);
    send(8'hD5); send(8'h00);
    push("lenmax1", 4'b0010, 8'd0);
    send(8'hD5); send(8'(MAXP + 1));
    drain();
    chk("t3_busy", 32'(busy), 32'd0);
    load123();
    send_pkt(3, 1'b1);
    drain();
    readback(3);
    ack();

    // maximum length packet, random payload
    for (int i = 0; i < MAXP; i++) pl[i] = 8'($urandom_range(0, 255));
    send_pkt(MAXP, 1'b1);
    drain();
    readback(MAXP);
    ack();

    // overrun while holding; buffer must survive
    load123();
    send_pkt(3, 1'b1);
    push("ovr", 4'b0100, 8'd0);
    send(8'h0D);
    drain();
    chk("t4_ready", 32'(packet_ready), 32'd1);
    readback(3);
    ack();

    // ack and byte in the same HOLD cycle
    send_pkt(3, 1'b1);
    push("ovr_ack", 4'b0100, 8'd0);
    @(posedge clk); #1;
    rx_data = 8'h0D; rx_done = 1'b1; packet_ack = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; packet_ack = 1'b0;
    drain();
    chk("ovrack_busy", 32'(busy), 32'd0);
    chk("ovrack_ready", 32'(packet_ready), 32'd0);

    // ack outside HOLD is ignored
    send(8'hD5); send(8'h03); send(8'h01);
    @(posedge clk); #1 packet_ack = 1'b1;
    @(posedge clk); #1 packet_ack = 1'b0;
    send(8'h02); send(8'h03);
    push("ackign", 4'b0000, 8'd3);
    send(8'hD8);
    drain();
    readback(3);
    ack();

    // junk bytes, then reset mid-packet
    send(8'h0D); send(8'h13);
    send_pkt(3, 1'b1);
    drain();
    ack();
    send(8'hD5); send(8'h03); send(8'h01);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    send_pkt(3, 1'b1);
    drain();
    readback(3);
    ack();

`ifdef S3G_RX_TIMEOUT_EN
    // inter-byte timeout
    send(8'hD5); send(8'h03);
    push("tmo", 4'b1000, 8'd0);
    send(8'h01);
    repeat (25) @(posedge clk);
    drain();
    chk("t6_busy", 32'(busy), 32'd0);
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
